class_search_ctrl: RTL and testbench

Sequencer for the class hypervector ROM (class_vec_gen). It accepts a query hypervector streamed in FRAME_WIDTH-bit frames and buffers it. It then walks every (frame_id, frame_index) pair of the ROM, accumulating per-class Hamming distance, and reports the class with minimum distance. It sits between the encoder output stream and the classification result interface.

---
 rtl/class_search_ctrl.sv | 168 ++++++++++++++++
 tb/tb_class_search_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/class_search_ctrl.sv
// Nearest-class search sequencer: buffers a streamed query, walks the class ROM and reports the minimum-Hamming-distance class.
// Optional build macro CLASS_SEARCH_EARLY_EXIT_EN stops the scan at the first class whose total distance is zero.
module class_search_ctrl #(
    parameter int FRAME_WIDTH = 64,
    parameter int NUM_CLASSES = 8,
    parameter int NUM_FRAMES  = 3,
    parameter int CLASS_W     = 3,
    parameter int FIDX_W      = 2,
    parameter int DIST_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [FRAME_WIDTH-1:0] q_data,
    input  logic                   q_valid,
    output logic                   q_ready,
    output logic [CLASS_W-1:0]     rom_frame_id,
    output logic [FIDX_W-1:0]      rom_frame_index,
    input  logic [FRAME_WIDTH-1:0] rom_data,
    output logic                   busy,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [CLASS_W-1:0]     res_class,
    output logic [DIST_W-1:0]      res_dist
);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [FIDX_W-1:0]  FRM_LAST = FIDX_W'(NUM_FRAMES - 1);
    localparam logic [CLASS_W-1:0] CLS_LAST = CLASS_W'(NUM_CLASSES - 1);

    function automatic logic [DIST_W-1:0] popcount(input logic [FRAME_WIDTH-1:0] v);
        logic [DIST_W-1:0] n;
        n = {DIST_W{1'b0}};
        for (int i = 0; i < FRAME_WIDTH; i++) begin
            n = n + DIST_W'(v[i]);
        end
        return n;
    endfunction

    logic [1:0]             state_r;
    logic                   q_ready_r;
    logic                   busy_r;
    logic [FIDX_W-1:0]      load_cnt_r;
    logic [FRAME_WIDTH-1:0] qbuf_r [NUM_FRAMES];
    logic [CLASS_W-1:0]     cls_r;
    logic [FIDX_W-1:0]      frm_r;
    logic [DIST_W-1:0]      acc_r;
    logic [DIST_W-1:0]      best_dist_r;
    logic [CLASS_W-1:0]     best_class_r;
    logic                   res_valid_r;
    logic [CLASS_W-1:0]     res_class_r;
    logic [DIST_W-1:0]      res_dist_r;

    logic [DIST_W-1:0]      sum_s;
    logic                   upd_s;
    logic [DIST_W-1:0]      fin_dist_s;
    logic [CLASS_W-1:0]     fin_class_s;
    logic                   exit_s;

    // Distance of the current class so far and the best-so-far after this class closes.
    always_comb begin
        sum_s       = acc_r + popcount(rom_data ^ qbuf_r[frm_r]);
        upd_s       = (sum_s < best_dist_r);
        fin_dist_s  = upd_s ? sum_s : best_dist_r;
        fin_class_s = upd_s ? cls_r : best_class_r;
`ifdef CLASS_SEARCH_EARLY_EXIT_EN
        // A zero distance cannot be beaten, so later classes cannot change the result.
        exit_s      = (cls_r == CLS_LAST) || (sum_s == {DIST_W{1'b0}});
`else
        exit_s      = (cls_r == CLS_LAST);
`endif
    end

    // Load / scan / done sequencer with registered handshake and ROM index outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_LOAD;
            q_ready_r    <= 1'b0;
            busy_r       <= 1'b0;
            load_cnt_r   <= {FIDX_W{1'b0}};
            for (int i = 0; i < NUM_FRAMES; i++) begin
                qbuf_r[i] <= {FRAME_WIDTH{1'b0}};
            end
            cls_r        <= {CLASS_W{1'b0}};
            frm_r        <= {FIDX_W{1'b0}};
            acc_r        <= {DIST_W{1'b0}};
            best_dist_r  <= {DIST_W{1'b0}};
            best_class_r <= {CLASS_W{1'b0}};
            res_valid_r  <= 1'b0;
            res_class_r  <= {CLASS_W{1'b0}};
            res_dist_r   <= {DIST_W{1'b0}};
        end else begin
            case (state_r)
                S_LOAD: begin
                    if (q_valid && q_ready_r) begin
                        qbuf_r[load_cnt_r] <= q_data;
                        if (load_cnt_r == FRM_LAST) begin
                            load_cnt_r   <= {FIDX_W{1'b0}};
                            state_r      <= S_SCAN;
                            q_ready_r    <= 1'b0;
                            busy_r       <= 1'b1;
                            cls_r        <= {CLASS_W{1'b0}};
                            frm_r        <= {FIDX_W{1'b0}};
                            acc_r        <= {DIST_W{1'b0}};
                            best_dist_r  <= {DIST_W{1'b1}};
                            best_class_r <= {CLASS_W{1'b0}};
                        end else begin
                            load_cnt_r <= load_cnt_r + FIDX_W'(1);
                            q_ready_r  <= 1'b1;
                        end
                    end else begin
                        q_ready_r <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (frm_r != FRM_LAST) begin
                        acc_r <= sum_s;
                        frm_r <= frm_r + FIDX_W'(1);
                    end else begin
                        acc_r        <= {DIST_W{1'b0}};
                        frm_r        <= {FIDX_W{1'b0}};
                        best_dist_r  <= fin_dist_s;
                        best_class_r <= fin_class_s;
                        if (exit_s) begin
                            state_r     <= S_DONE;
                            cls_r       <= {CLASS_W{1'b0}};
                            res_valid_r <= 1'b1;
                            res_class_r <= fin_class_s;
                            res_dist_r  <= fin_dist_s;
                        end else begin
                            cls_r <= cls_r + CLASS_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        state_r     <= S_LOAD;
                        q_ready_r   <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        res_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= S_LOAD;
                    q_ready_r   <= 1'b0;
                    busy_r      <= 1'b0;
                    res_valid_r <= 1'b0;
                    cls_r       <= {CLASS_W{1'b0}};
                    frm_r       <= {FIDX_W{1'b0}};
                    load_cnt_r  <= {FIDX_W{1'b0}};
                end
            endcase
        end
    end

    assign q_ready         = q_ready_r;
    assign busy            = busy_r;
    assign rom_frame_id    = cls_r;
    assign rom_frame_index = frm_r;
    assign res_valid       = res_valid_r;
    assign res_class       = res_class_r;
    assign res_dist        = res_dist_r;

endmodule

// File: tb/tb_class_search_ctrl.sv
// Directed bench for class_search_ctrl with a behavioural ROM (class c frame = low c bits set).
// Latency expectations follow CLASS_SEARCH_EARLY_EXIT_EN when the bench is built with it.
module tb_class_search_ctrl;

    logic        clk;
    logic        rst_n;
    logic [63:0] q_data;
    logic        q_valid;
    logic        q_ready;
    logic [2:0]  rom_frame_id;
    logic [1:0]  rom_frame_index;
    logic [63:0] rom_data;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_class;
    logic [7:0]  res_dist;

    logic        tie_mode;
    int          total;
    int          bad;

    class_search_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .q_data          (q_data),
        .q_valid         (q_valid),
        .q_ready         (q_ready),
        .rom_frame_id    (rom_frame_id),
        .rom_frame_index (rom_frame_index),
        .rom_data        (rom_data),
        .busy            (busy),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_class       (res_class),
        .res_dist        (res_dist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model, combinational from the registered indices.
    always_comb begin
        if (tie_mode && (rom_frame_id == 3'd2 || rom_frame_id == 3'd5)) begin
            rom_data = 64'hF0;
        end else begin
            rom_data = (64'h1 << rom_frame_id) - 64'h1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [63:0] d);
        int guard;
        guard = 0;
        q_data  = d;
        q_valid = 1'b1;
        while (!q_ready && guard < 50) begin
            step();
            guard++;
        end
        chk("q_ready_before_send", {63'd0, q_ready}, 64'd1);
        step();
        q_valid = 1'b0;
    endtask

    task automatic send3(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        send_frame(a);
        send_frame(b);
        send_frame(c);
    endtask

    // Called in cycle T+1 after the last handshake; checks the cycle index at which res_valid rises.
    task automatic wait_res(input string tag, input int exp_lat);
        int cnt;
        cnt = 1;
        while (!res_valid && cnt < 100) begin
            step();
            cnt++;
        end
        chk(tag, 64'(cnt), 64'(exp_lat));
        chk("res_valid_high", {63'd0, res_valid}, 64'd1);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("res_valid_drop", {63'd0, res_valid}, 64'd0);
        chk("q_ready_after_consume", {63'd0, q_ready}, 64'd1);
        chk("busy_after_consume", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] st_frames [3];
        logic [5:0]  pat;
        int          fi;
        total    = 0;
        bad      = 0;
        tie_mode = 1'b0;
        rst_n    = 1'b0;
        q_valid  = 1'b0;
        q_data   = 64'd0;
        res_ready = 1'b0;

        // Reset values and q_ready rising on the first clock after release.
        step();
        step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_res_class", {61'd0, res_class}, 64'd0);
        chk("rst_res_dist", {56'd0, res_dist}, 64'd0);
        chk("rst_rom_id", {61'd0, rom_frame_id}, 64'd0);
        chk("rst_rom_idx", {62'd0, rom_frame_index}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_q_ready_low", {63'd0, q_ready}, 64'd0);
        step();
        chk("rst_q_ready_high", {63'd0, q_ready}, 64'd1);

        // All-zero query: class 0 at distance 0.
        send3(64'd0, 64'd0, 64'd0);
        chk("zero_q_ready_low", {63'd0, q_ready}, 64'd0);
        chk("zero_busy", {63'd0, busy}, 64'd1);
`ifdef CLASS_SEARCH_EARLY_EXIT_EN
        wait_res("zero_latency", 4);
`else
        wait_res("zero_latency", 25);
`endif
        chk("zero_class", {61'd0, res_class}, 64'd0);
        chk("zero_dist", {56'd0, res_dist}, 64'd0);
        consume();

        // All-ones query: class 7 at 3*(64-7)=171, then back-pressure.
        send3(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_res("ones_latency", 25);
        chk("ones_class", {61'd0, res_class}, 64'd7);
        chk("ones_dist", {56'd0, res_dist}, 64'd171);
        for (int i = 0; i < 10; i++) begin
            q_valid = i[0];
            q_data  = 64'h1234;
            step();
            chk("bp_res_valid", {63'd0, res_valid}, 64'd1);
            chk("bp_res_class", {61'd0, res_class}, 64'd7);
            chk("bp_res_dist", {56'd0, res_dist}, 64'd171);
            chk("bp_q_ready", {63'd0, q_ready}, 64'd0);
        end
        q_valid = 1'b0;
        consume();
        chk("hold_res_class", {61'd0, res_class}, 64'd7);
        chk("hold_res_dist", {56'd0, res_dist}, 64'd171);

        // Tie between classes 2 and 5: lowest index wins.
        tie_mode = 1'b1;
        send3(64'hF0, 64'hF0, 64'hF0);
`ifdef CLASS_SEARCH_EARLY_EXIT_EN
        wait_res("tie_latency", 10);
`else
        wait_res("tie_latency", 25);
`endif
        chk("tie_class", {61'd0, res_class}, 64'd2);
        chk("tie_dist", {56'd0, res_dist}, 64'd0);
        consume();
        tie_mode = 1'b0;

        // Stalled load with q_valid 1,0,0,1,0,1; per-class sums 10,9,8,9,10,11,... -> class 2, dist 8.
        st_frames[0] = 64'hFF;
        st_frames[1] = 64'h0;
        st_frames[2] = 64'h3;
        pat = 6'b101001;
        fi  = 0;
        for (int i = 0; i < 6; i++) begin
            q_valid = pat[i];
            q_data  = st_frames[fi];
            chk("stall_q_ready", {63'd0, q_ready}, 64'd1);
            step();
            if (pat[i]) begin
                fi++;
            end else begin
                fi = fi;
            end
        end
        q_valid = 1'b0;
        for (int k = 0; k < 24; k++) begin
            chk("stall_rom_id", {61'd0, rom_frame_id}, 64'(k / 3));
            chk("stall_rom_idx", {62'd0, rom_frame_index}, 64'(k % 3));
            step();
        end
        chk("stall_res_valid", {63'd0, res_valid}, 64'd1);
        chk("stall_class", {61'd0, res_class}, 64'd2);
        chk("stall_dist", {56'd0, res_dist}, 64'd8);
        consume();

        // Reset asserted in SCAN cycle 10 clears everything asynchronously.
        send3(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 9; i++) begin
            step();
        end
        chk("scan_busy_pre_abort", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_q_ready", {63'd0, q_ready}, 64'd0);
        chk("abort_res_valid", {63'd0, res_valid}, 64'd0);
        chk("abort_res_class", {61'd0, res_class}, 64'd0);
        chk("abort_res_dist", {56'd0, res_dist}, 64'd0);
        chk("abort_rom_id", {61'd0, rom_frame_id}, 64'd0);
        chk("abort_rom_idx", {62'd0, rom_frame_index}, 64'd0);
        #2;
        rst_n = 1'b1;
        step();
        send3(64'd0, 64'd0, 64'd0);
`ifdef CLASS_SEARCH_EARLY_EXIT_EN
        wait_res("fresh_latency", 4);
`else
        wait_res("fresh_latency", 25);
`endif
        chk("fresh_class", {61'd0, res_class}, 64'd0);
        chk("fresh_dist", {56'd0, res_dist}, 64'd0);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
